uart_rx_param: RTL

//  Parametrised UART receiver; successor to the fixed 8N1 receiver. Configurable data length, parity and stop

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sampler.sv | 64 ++++++
 rtl/uart_rx_param.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-level helper functions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Widest legal data word is 9 bits; narrower words are zero-extended by the caller.
  function automatic logic parity9(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: rx synchroniser, falling-edge detect, tick counter
// and 3-sample majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  input  logic baud_timer,
  input  logic idle,
  output logic start_edge,
  output logic bit_valid,
  output logic bit_value,
  output logic bit_end
);

  localparam logic [3:0] CNT_MAX = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID     = 4'(OVERSAMPLE / 2);

  logic       sync1_r;
  logic       rxs_r;
  logic       prev_r;
  logic [3:0] cnt_r;
  logic       samp0_r;
  logic       samp1_r;

  // Synchroniser, edge history, tick counter and the two early votes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
      prev_r  <= 1'b1;
      cnt_r   <= 4'd0;
      samp0_r <= 1'b1;
      samp1_r <= 1'b1;
    end else begin
      sync1_r <= rx;
      rxs_r   <= sync1_r;
      prev_r  <= rxs_r;
      // A start edge re-phases the counter so votes land mid-bit.
      if (idle && start_edge) begin
        cnt_r <= 4'd0;
      end else if (baud_timer) begin
        cnt_r <= (cnt_r == CNT_MAX) ? 4'd0 : cnt_r + 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (baud_timer && (cnt_r == MID - 4'd1)) begin
        samp0_r <= rxs_r;
      end
      if (baud_timer && (cnt_r == MID)) begin
        samp1_r <= rxs_r;
      end
    end
  end

  assign start_edge = prev_r & ~rxs_r;
  assign bit_valid  = baud_timer && (cnt_r == MID + 4'd1);
  assign bit_value  = maj3(samp0_r, samp1_r, rxs_r);
  assign bit_end    = baud_timer && (cnt_r == CNT_MAX);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, shift register and a one-entry holding
// register presented on a valid/ready interface.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx,
  input  logic                   baud_timer,
  input  logic                   rx_ready,
  output logic                   rx_valid,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam logic [3:0] LAST_BIT  = 4'(DATA_LENGTH - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       ODD       = 1'(PARITY_ODD);
  localparam logic       PAR_ON    = 1'(PARITY_EN);

  rx_state_e              state_r;
  logic [3:0]             bit_idx_r;
  logic                   stop_idx_r;
  logic [DATA_LENGTH-1:0] shift_r;
  logic                   par_err_r;
  logic                   frm_err_r;
  logic                   done_r;
  logic                   idle_s;
  logic                   start_edge_s;
  logic                   bit_valid_s;
  logic                   bit_value_s;
  logic                   bit_end_s;

  assign idle_s = (state_r == ST_IDLE);

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .baud_timer (baud_timer),
    .idle       (idle_s),
    .start_edge (start_edge_s),
    .bit_valid  (bit_valid_s),
    .bit_value  (bit_value_s),
    .bit_end    (bit_end_s)
  );

  // Frame FSM: walks start/data/parity/stop bits and flags a completed frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      bit_idx_r  <= 4'd0;
      stop_idx_r <= 1'b0;
      shift_r    <= '0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_edge_s) begin
            state_r    <= ST_START;
            bit_idx_r  <= 4'd0;
            stop_idx_r <= 1'b0;
            par_err_r  <= 1'b0;
            frm_err_r  <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_valid_s && bit_value_s) begin
            state_r <= ST_IDLE;
          end else if (bit_end_s) begin
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_valid_s) begin
            shift_r <= {bit_value_s, shift_r[DATA_LENGTH-1:1]};
          end
          if (bit_end_s) begin
            bit_idx_r <= bit_idx_r + 4'd1;
            if (bit_idx_r == LAST_BIT) begin
              state_r <= PAR_ON ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (bit_valid_s) begin
            par_err_r <= ((parity9(9'(shift_r)) ^ bit_value_s) != ODD);
          end
          if (bit_end_s) begin
            state_r <= ST_STOP;
          end
        end
        ST_STOP: begin
          // The last stop bit finishes at its vote so a following start edge is not missed.
          if (bit_valid_s) begin
            if (!bit_value_s) begin
              frm_err_r <= 1'b1;
            end
            if (stop_idx_r == LAST_STOP) begin
              state_r <= ST_IDLE;
              done_r  <= 1'b1;
            end
          end else if (bit_end_s) begin
            stop_idx_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Holding register: load on completion unless full and not being drained.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_r) begin
        if (!rx_valid || rx_ready) begin
          rx_valid   <= 1'b1;
          rx_data    <= shift_r;
          parity_err <= par_err_r;
          frame_err  <= frm_err_r;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
